// File: rtl/conv2d_pkg.sv
// ---------------------------------------------------------------------------
// conv2d_pkg
// Shared definitions for the streaming 2-D convolution engine:
//   - controller state encodings
//   - default DWIDTH / WT_DIM / MAX_FM_DIM values
//   - clog2_min1 helper that never returns a zero-width result
// No ports (package).
// ---------------------------------------------------------------------------
package conv2d_pkg;

    localparam int DEF_DWIDTH     = 32;
    localparam int DEF_WT_DIM     = 3;
    localparam int DEF_MAX_FM_DIM = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ_WT = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Address width for a table of 'value' entries, at least one bit wide.
    function automatic int clog2_min1(input int value);
        if (value <= 1) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// ---------------------------------------------------------------------------
// conv2d_line_buffer
// Holds the WT_DIM-1 most recent padded rows of the feature map as circular
// row buffers of depth MAX_FM_DIM. A rotating pointer selects the row being
// overwritten; because that row is the oldest one held, reading all rows at
// the current column (before the write lands) gives the kernel column above
// the incoming pixel.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (row pointer only)
//   wr_en    in   write wr_data into the current row at column 'col'
//   col      in   column index (unpadded IFM column)
//   wr_data  in   pixel value to store
//   row_adv  in   rotate to the next row buffer (end of a padded row)
//   rd_data  out  column 'col' of every buffered row, oldest row at index 0
// ---------------------------------------------------------------------------
module conv2d_line_buffer
    import conv2d_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int WT_DIM     = DEF_WT_DIM,
    parameter int MAX_FM_DIM = DEF_MAX_FM_DIM,
    localparam int AW        = clog2_min1(MAX_FM_DIM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [AW-1:0]                   col,
    input  logic [DWIDTH-1:0]               wr_data,
    input  logic                            row_adv,
    output logic [WT_DIM-2:0][DWIDTH-1:0]   rd_data
);

    localparam int NROWS = WT_DIM - 1;
    localparam int PW    = clog2_min1(NROWS);
    localparam logic [PW-1:0] LAST_ROW = PW'(NROWS - 1);

    // Row storage is written in place; it is never reset because every entry
    // a job reads has been written earlier in that same job.
    logic [DWIDTH-1:0] row_mem_q [NROWS][MAX_FM_DIM];
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [PW-1:0]     rd_idx;

    always_comb begin
        ptr_d = ptr_q;
        if (row_adv) begin
            ptr_d = (ptr_q == LAST_ROW) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_mem_q[ptr_q][col] <= wr_data;
        end
    end

    // Row ptr_q holds the oldest row, ptr_q+1 the next one and so on
    // (modulo NROWS), so output k is the row at ptr_q + k.
    always_comb begin
        rd_data = '0;
        rd_idx  = '0;
        for (int k = 0; k < NROWS; k++) begin
            rd_idx = ptr_q;
            for (int j = 0; j < k; j++) begin
                rd_idx = (rd_idx == LAST_ROW) ? '0 : rd_idx + PW'(1);
            end
            rd_data[k] = row_mem_q[rd_idx][col];
        end
    end

endmodule

// File: rtl/conv2d_stream_compute.sv
// ---------------------------------------------------------------------------
// conv2d_stream_compute
// Streaming "same"-size 2-D convolution. A job loads WT_DIM*WT_DIM weights
// from the inbound stream, then walks a zero-padded (fm_dim+2P)^2 grid,
// consuming one IFM pixel per interior position and injecting zeros on the
// halo. A WT_DIM x WT_DIM window fed by the line buffers drives a MAC whose
// result is registered onto the outbound stream.
//
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   start        in   begin a job (sampled in IDLE)
//   idle         out  high only in IDLE
//   err          out  sticky: last start had an unsupported fm_dim
//   fm_dim       in   feature-map edge length, sampled with start
//   rdata        in   weights then IFM pixels (signed)
//   rdata_valid  in   inbound valid
//   rdata_ready  out  inbound ready
//   wdata        out  OFM result (registered)
//   wdata_valid  out  outbound valid (registered)
//   wdata_ready  in   outbound ready
//
// Configuration macro: CONV2D_RELU_EN -- when defined, negative results are
// clamped to zero before being registered into wdata.
// ---------------------------------------------------------------------------
module conv2d_stream_compute
    import conv2d_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int WT_DIM     = DEF_WT_DIM,
    parameter int MAX_FM_DIM = DEF_MAX_FM_DIM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              idle,
    output logic              err,
    input  logic [31:0]       fm_dim,
    input  logic [DWIDTH-1:0] rdata,
    input  logic              rdata_valid,
    output logic              rdata_ready,
    output logic [DWIDTH-1:0] wdata,
    output logic              wdata_valid,
    input  logic              wdata_ready
);

    localparam int P   = (WT_DIM - 1) / 2;
    localparam int NWT = WT_DIM * WT_DIM;
    localparam int AW  = clog2_min1(MAX_FM_DIM);
    localparam int CW  = clog2_min1(MAX_FM_DIM + WT_DIM) + 1;
    localparam int OCW = 2 * CW;
    localparam int WCW = clog2_min1(NWT);

    localparam logic [CW-1:0]  P_C     = CW'(P);
    localparam logic [CW-1:0]  TWO_P_C = CW'(2 * P);
    localparam logic [WCW-1:0] LAST_WT = WCW'(NWT - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     x_q, x_d;
    logic [CW-1:0]     y_q, y_d;
    logic [WCW-1:0]    wt_cnt_q, wt_cnt_d;
    logic [OCW-1:0]    out_cnt_q, out_cnt_d;
    logic              walk_done_q, walk_done_d;
    logic              win_emit_q, win_emit_d;
    logic              err_q, err_d;
    logic              wdata_valid_q, wdata_valid_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;

    logic [DWIDTH-1:0] w_q   [NWT];
    logic [DWIDTH-1:0] w_d   [NWT];
    logic [DWIDTH-1:0] win_q [WT_DIM][WT_DIM];
    logic [DWIDTH-1:0] win_d [WT_DIM][WT_DIM];

    logic [CW-1:0]     last_pos;
    logic              halo_col;
    logic              halo_row;
    logic              interior;
    logic              stall;
    logic              walk_active;
    logic              step;
    logic              emit_pos;
    logic [DWIDTH-1:0] pixel;
    logic              lb_wr_en;
    logic [AW-1:0]     lb_col;
    logic              row_adv;
    logic [OCW-1:0]    total;
    logic [WT_DIM-2:0][DWIDTH-1:0] lb_rd;

    logic [DWIDTH-1:0] mac_prod;
    logic [DWIDTH-1:0] mac_acc;
    logic [DWIDTH-1:0] mac_res;

    conv2d_line_buffer #(
        .DWIDTH     (DWIDTH),
        .WT_DIM     (WT_DIM),
        .MAX_FM_DIM (MAX_FM_DIM)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lb_wr_en),
        .col     (lb_col),
        .wr_data (pixel),
        .row_adv (row_adv),
        .rd_data (lb_rd)
    );

    // Position decode and handshake. The walk freezes whenever a held output
    // is not being taken, so the window never overwrites an unsent result.
    always_comb begin
        last_pos    = n_q + TWO_P_C - CW'(1);
        halo_col    = (x_q < P_C) || (x_q >= n_q + P_C);
        halo_row    = (y_q < P_C) || (y_q >= n_q + P_C);
        interior    = !halo_col && !halo_row;
        stall       = wdata_valid_q && !wdata_ready;
        walk_active = (state_q == ST_COMPUTE) && !walk_done_q && !stall;
        rdata_ready = (state_q == ST_READ_WT) || (walk_active && interior);
        step        = walk_active && (!interior || rdata_valid);
        // The window is centred on IFM(y-2P, x-2P) once (y,x) has shifted in.
        emit_pos    = (x_q >= TWO_P_C) && (y_q >= TWO_P_C);
        pixel       = halo_row ? '0 : rdata;
        // Halo rows still write zeros so the buffered rows above row 0 read
        // as padding; halo columns are never stored.
        lb_wr_en    = step && !halo_col;
        lb_col      = AW'(x_q - P_C);
        row_adv     = step && (x_q == last_pos);
        total       = OCW'(n_q) * OCW'(n_q);
    end

    // Window shifts left by one column per step; a halo column enters as zeros.
    always_comb begin
        win_d = win_q;
        if (step) begin
            for (int i = 0; i < WT_DIM; i++) begin
                for (int j = 0; j < WT_DIM - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            for (int i = 0; i < WT_DIM - 1; i++) begin
                win_d[i][WT_DIM-1] = halo_col ? '0 : lb_rd[i];
            end
            win_d[WT_DIM-1][WT_DIM-1] = halo_col ? '0 : pixel;
        end
    end

    // Weights arrive row-major; READ_WT always presents rdata_ready.
    always_comb begin
        w_d = w_q;
        if ((state_q == ST_READ_WT) && rdata_valid) begin
            w_d[wt_cnt_q] = rdata;
        end
    end

    // Low DWIDTH bits of each product are the same for signed and unsigned
    // operands, which gives the required mod 2^DWIDTH behaviour directly.
    always_comb begin
        mac_prod = '0;
        mac_acc  = '0;
        for (int i = 0; i < WT_DIM; i++) begin
            for (int j = 0; j < WT_DIM; j++) begin
                mac_prod = w_q[i*WT_DIM + j] * win_q[i][j];
                mac_acc  = mac_acc + mac_prod;
            end
        end
`ifdef CONV2D_RELU_EN
        mac_res = mac_acc[DWIDTH-1] ? '0 : mac_acc;
`else
        mac_res = mac_acc;
`endif
    end

    // Controller: job acceptance, weight count, padded walk, output register.
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        x_d           = x_q;
        y_d           = y_q;
        wt_cnt_d      = wt_cnt_q;
        out_cnt_d     = out_cnt_q;
        walk_done_d   = walk_done_q;
        win_emit_d    = win_emit_q;
        err_d         = err_q;
        wdata_valid_d = wdata_valid_q;
        wdata_d       = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((fm_dim >= 32'd1) && (fm_dim <= 32'(MAX_FM_DIM))) begin
                        state_d     = ST_READ_WT;
                        n_d         = fm_dim[CW-1:0];
                        err_d       = 1'b0;
                        x_d         = '0;
                        y_d         = '0;
                        wt_cnt_d    = '0;
                        out_cnt_d   = '0;
                        walk_done_d = 1'b0;
                        win_emit_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_READ_WT: begin
                if (rdata_valid) begin
                    if (wt_cnt_q == LAST_WT) begin
                        wt_cnt_d = '0;
                        state_d  = ST_COMPUTE;
                    end else begin
                        wt_cnt_d = wt_cnt_q + WCW'(1);
                    end
                end
            end

            ST_COMPUTE: begin
                if (step) begin
                    if (x_q == last_pos) begin
                        x_d = '0;
                        if (y_q == last_pos) begin
                            walk_done_d = 1'b1;
                        end else begin
                            y_d = y_q + CW'(1);
                        end
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
                // The output register takes the window result whenever it
                // is empty or being drained this cycle.
                if (!stall) begin
                    win_emit_d    = step && emit_pos;
                    wdata_valid_d = win_emit_q;
                    if (win_emit_q) begin
                        wdata_d = mac_res;
                    end
                end
                if (wdata_valid_q && wdata_ready) begin
                    out_cnt_d = out_cnt_q + OCW'(1);
                    if (out_cnt_q == total - OCW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            n_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            wt_cnt_q      <= '0;
            out_cnt_q     <= '0;
            walk_done_q   <= 1'b0;
            win_emit_q    <= 1'b0;
            err_q         <= 1'b0;
            wdata_valid_q <= 1'b0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            x_q           <= x_d;
            y_q           <= y_d;
            wt_cnt_q      <= wt_cnt_d;
            out_cnt_q     <= out_cnt_d;
            walk_done_q   <= walk_done_d;
            win_emit_q    <= win_emit_d;
            err_q         <= err_d;
            wdata_valid_q <= wdata_valid_d;
            wdata_q       <= wdata_d;
        end
    end

    // Weights and window are fully reloaded by every job before use.
    always_ff @(posedge clk) begin
        w_q   <= w_d;
        win_q <= win_d;
    end

    assign idle        = (state_q == ST_IDLE);
    assign err         = err_q;
    assign wdata       = wdata_q;
    assign wdata_valid = wdata_valid_q;

endmodule

// File: tb/tb_conv2d_stream_compute.sv
// ---------------------------------------------------------------------------
// tb_conv2d_stream_compute
// Directed and randomized jobs for conv2d_stream_compute, checked against a
// "same"-padding convolution computed directly from the IFM and weights.
// ---------------------------------------------------------------------------
module tb_conv2d_stream_compute;

    localparam int DW   = 32;
    localparam int K    = 3;
    localparam int P    = (K - 1) / 2;
    localparam int MAXD = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          idle;
    logic          err;
    logic [31:0]   fm_dim;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          rdata_ready;
    logic [DW-1:0] wdata;
    logic          wdata_valid;
    logic          wdata_ready;

    int n_compared   = 0;
    int n_mismatched = 0;

    int wts[$];
    int ifm[$];
    int exp_q[$];

    always #5 clk = ~clk;

    conv2d_stream_compute #(
        .DWIDTH     (DW),
        .WT_DIM     (K),
        .MAX_FM_DIM (MAXD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .idle        (idle),
        .err         (err),
        .fm_dim      (fm_dim),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag,
                   $signed(observed), $signed(expected));
        end
    endtask

    // Reference: zero-padded correlation straight from the definition.
    task automatic buildModel(input int n);
        exp_q.delete();
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                int acc;
                acc = 0;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        int rr;
                        int cc;
                        rr = r + i - P;
                        cc = c + j - P;
                        if (rr >= 0 && rr < n && cc >= 0 && cc < n) begin
                            acc = acc + wts[i*K + j] * ifm[rr*n + cc];
                        end
                    end
                end
`ifdef CONV2D_RELU_EN
                if (acc < 0) acc = 0;
`endif
                exp_q.push_back(acc);
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_idle"}, idle, 1);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_rready"}, rdata_ready, 0);
        checkOutput({tag, "_wvalid"}, wdata_valid, 0);
        checkOutput({tag, "_wdata"}, wdata, 0);
    endtask

    // Runs one job: wmode 0 = always ready, 1 = toggling, 2 = random.
    // abort_after > 0 returns early once that many results were taken.
    task automatic applyStimulus(input int n, input int wmode, input bit gaps,
                                 input int abort_after);
        int          stim[$];
        int          got;
        int          cycles;
        int          budget;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        rr, rv, wv, wr;
        logic [31:0] wd;
        stim       = {wts, ifm};
        got        = 0;
        cycles     = 0;
        budget     = 30 * (n + 2) * (n + 2) + 200;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (cycles < budget) begin
            @(negedge clk);
            start  = (cycles < 2);
            fm_dim = (cycles == 0) ? n : $urandom;
            if (stim.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                rdata_valid = 1'b1;
                rdata       = stim[0];
            end else begin
                rdata_valid = 1'b0;
                rdata       = $urandom;
            end
            case (wmode)
                0:       wdata_ready = 1'b1;
                1:       wdata_ready = cycles[0];
                default: wdata_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            rr = rdata_ready;
            rv = rdata_valid;
            wv = wdata_valid;
            wr = wdata_ready;
            wd = wdata;
            if (cycles == 1) begin
                checkOutput("busy_idle", idle, 0);
                checkOutput("err_clear", err, 0);
            end
            if (prev_stall) begin
                checkOutput("hold_valid", wv, 1);
                checkOutput("hold_data", wd, prev_data);
            end
            if (wv && !wr) checkOutput("stall_rready", rr, 0);
            if (cycles > 1 && got == exp_q.size() && idle === 1'b1) break;
            @(posedge clk);
            if (rv && rr) void'(stim.pop_front());
            if (wv && wr) begin
                if (got < exp_q.size()) checkOutput("ofm", wd, exp_q[got]);
                else checkOutput("ofm_extra", got + 1, exp_q.size());
                got++;
            end
            prev_stall = wv && !wr;
            prev_data  = wd;
            cycles++;
            if (abort_after > 0 && got >= abort_after) break;
        end
        start       = 1'b0;
        rdata_valid = 1'b0;
        if (abort_after <= 0) begin
            checkOutput("ofm_count", got, exp_q.size());
            checkOutput("ifm_consumed", stim.size(), 0);
            checkOutput("idle_end", idle, 1);
            checkOutput("wvalid_end", wdata_valid, 0);
        end
    endtask

    task automatic badStart(input int dim);
        @(negedge clk);
        start       = 1'b1;
        fm_dim      = dim;
        rdata_valid = 1'b1;
        wdata_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("bad_err", err, 1);
        checkOutput("bad_idle", idle, 1);
        checkOutput("bad_rready", rdata_ready, 0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("bad_err_sticky", err, 1);
        checkOutput("bad_rready_late", rdata_ready, 0);
        rdata_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        start       = 1'b0;
        fm_dim      = '0;
        rdata       = '0;
        rdata_valid = 1'b0;
        wdata_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;

        $display("[TB] identity kernel, fm_dim=4");
        wts = {0, 0, 0, 0, 1, 0, 0, 0, 0};
        ifm.delete();
        for (int i = 1; i <= 16; i++) ifm.push_back(i);
        exp_q = ifm;
        applyStimulus(4, 0, 1'b0, 0);

        $display("[TB] ones kernel, fm_dim=3");
        wts   = {1, 1, 1, 1, 1, 1, 1, 1, 1};
        ifm   = {1, 1, 1, 1, 1, 1, 1, 1, 1};
        exp_q = {4, 6, 4, 6, 9, 6, 4, 6, 4};
        applyStimulus(3, 0, 1'b0, 0);

        $display("[TB] backpressure, identity kernel, fm_dim=4");
        wts = {0, 0, 0, 0, 1, 0, 0, 0, 0};
        ifm.delete();
        for (int i = 1; i <= 16; i++) ifm.push_back(i);
        exp_q = ifm;
        applyStimulus(4, 1, 1'b1, 0);

        $display("[TB] size limits");
        badStart(0);
        wts   = {0, 0, 0, 0, 3, 0, 0, 0, 0};
        ifm   = {7};
        exp_q = {21};
        applyStimulus(1, 0, 1'b0, 0);
        badStart(MAXD + 1);

        $display("[TB] negative results");
        wts = {0, 0, 0, 0, -1, 0, 0, 0, 0};
        ifm = {5, -2, 0, 4};
`ifdef CONV2D_RELU_EN
        exp_q = {0, 2, 0, 0};
`else
        exp_q = {-5, 2, 0, -4};
`endif
        applyStimulus(2, 0, 1'b0, 0);

        $display("[TB] randomized jobs");
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 7);
            wts.delete();
            ifm.delete();
            for (int i = 0; i < K * K; i++) begin
                wts.push_back((t < 3) ? $urandom_range(0, 20) - 10 : $urandom);
            end
            for (int i = 0; i < n * n; i++) begin
                ifm.push_back((t < 3) ? $urandom_range(0, 200) - 100 : $urandom);
            end
            buildModel(n);
            applyStimulus(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] largest feature map");
        wts.delete();
        ifm.delete();
        for (int i = 0; i < K * K; i++) wts.push_back($urandom_range(0, 14) - 7);
        for (int i = 0; i < MAXD * MAXD; i++) ifm.push_back($urandom_range(0, 1000) - 500);
        buildModel(MAXD);
        applyStimulus(MAXD, 2, 1'b1, 0);

        $display("[TB] reset during compute");
        wts   = {1, 1, 1, 1, 1, 1, 1, 1, 1};
        ifm   = {1, 1, 1, 1, 1, 1, 1, 1, 1};
        exp_q = {4, 6, 4, 6, 9, 6, 4, 6, 4};
        applyStimulus(3, 0, 1'b0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkResetState("midjob_reset");
        rst_n = 1'b1;
        applyStimulus(3, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/conv2d_stream_compute.md
CONV2D_STREAM_COMPUTE -- requirements
Module: conv2d_stream_compute

Interface
REQ-001 Parameter DWIDTH, default 32: data, weight and result width in bits.
REQ-002 Parameter WT_DIM, default 3: kernel edge length; odd and at least 3; P = (WT_DIM-1)/2.
REQ-003 Parameter MAX_FM_DIM, default 64: largest supported feature-map edge; sizes the line buffers.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  begins one convolution job when sampled high in IDLE.
REQ-007 idle  output  1  high only in IDLE.
REQ-008 err  output  1  sticky flag for a rejected fm_dim; cleared by the next accepted start.
REQ-009 fm_dim  input  32  feature-map edge; sampled on the start cycle.
REQ-010 rdata / rdata_valid / rdata_ready  input DWIDTH / input 1 / output 1  inbound stream carrying the weights, then the input feature map (IFM).
REQ-011 wdata / wdata_valid / wdata_ready  output DWIDTH / output 1 / input 1  outbound output-feature-map (OFM) stream.

Function
REQ-012 States: IDLE, READ_WT, COMPUTE, DONE.
REQ-013 IDLE to READ_WT on start when 1 <= fm_dim <= MAX_FM_DIM.
  - For any other fm_dim: stay in IDLE and set err.
REQ-014 READ_WT accepts exactly WT_DIM*WT_DIM weights, row-major, one per rdata fire (valid & ready), then moves to COMPUTE on the next edge.
REQ-015 COMPUTE walks padded coordinates (y,x), each from 0 to fm_dim+2P-1, row-major, advancing by one position per non-stalled cycle.
REQ-016 At halo positions (x or y < P, or x or y >= fm_dim+P) the engine injects zero, holds rdata_ready low, and consumes nothing.
REQ-017 At interior positions rdata_ready is high while not stalled; the position advances only on an rdata fire.
REQ-018 Consumed IFM pixels are written to WT_DIM-1 line buffers of depth MAX_FM_DIM; these feed a WT_DIM x WT_DIM window register array.
REQ-019 Once the window is centred on IFM(r,c), the engine emits OFM(r,c) = sum of w[i][j]*win[i][j].
  - Output is "same" size: exactly fm_dim*fm_dim results, row-major.
REQ-020 Arithmetic is signed two's complement; each product and the accumulation are truncated mod 2^DWIDTH.
REQ-021 wdata/wdata_valid are registered outputs.
  - OFM(r,c) is valid no later than 2 cycles after the fire of IFM(min(r+P,fm_dim-1), min(c+P,fm_dim-1)), or after the corresponding halo step.
REQ-022 While wdata_valid & ~wdata_ready: wdata holds stable, the coordinate walk freezes, and rdata_ready is low.
  - No result is dropped or duplicated.
REQ-023 COMPUTE to DONE on the fire of the last OFM; DONE lasts one cycle, then IDLE.
REQ-024 start outside IDLE is ignored; fm_dim changes after the start cycle are ignored.

Reset
REQ-025 With rst_n low at a clock edge: state = IDLE, all counters = 0, idle = 1, err = 0, rdata_ready = 0, wdata_valid = 0, wdata = 0.
REQ-026 Reset mid-job abandons the job; line-buffer and weight contents need not be cleared.
  - The first job after reset still produces correct results.

Configuration
REQ-027 Macro CONV2D_RELU_EN defined: each result is clamped to 0 when negative before registering into wdata.
REQ-028 Macro CONV2D_RELU_EN absent: the raw signed result is output; no clamp logic is synthesised.

Structure
REQ-029 Shared package conv2d_pkg holds:
  - state encodings (IDLE=0, READ_WT=1, COMPUTE=2, DONE=3);
  - default DWIDTH / WT_DIM / MAX_FM_DIM constants.
REQ-030 Sub-module conv2d_line_buffer (parameters DWIDTH, WT_DIM, MAX_FM_DIM) implements the WT_DIM-1 circular row buffers with write enable and column index.
  - The top level owns the FSM, counters, window, multiply-accumulate (MAC) tree and output register.

Verification
REQ-031 Identity test: WT_DIM=3, weights 0,0,0,0,1,0,0,0,0, fm_dim=4, IFM 1..16 -> OFM 1..16 in order, then idle=1.
REQ-032 Ones test: all-ones kernel, fm_dim=3, IFM all 1 -> OFM 4,6,4,6,9,6,4,6,4.
REQ-033 Backpressure test: identity kernel, fm_dim=4, wdata_ready toggling every cycle plus random rdata_valid gaps -> identical 16 outputs, none lost or repeated, wdata stable while stalled.
REQ-034 Size limits: fm_dim=1, centre weight 3, IFM 7 -> single OFM 21. fm_dim=0 or MAX_FM_DIM+1 -> err=1, idle stays 1, no rdata_ready.
REQ-035 ReLU test: centre weight -1, fm_dim=2, IFM 5,-2,0,4 -> 0,2,0,0 with CONV2D_RELU_EN; -5,2,0,-4 without.
REQ-036 Reset test: rst_n low during COMPUTE -> all outputs at reset values next cycle; a following job with the REQ-032 stimulus gives the REQ-032 outputs.
